// File: rtl/sseg_edit_pkg.sv
// Shared types and constants for the 7-segment digit editor.
package sseg_edit_pkg;

  typedef enum logic {IDLE, EDIT} state_e;

  // Button priority order: lower index wins when pulses coincide.
  localparam int unsigned BTN_C   = 0;
  localparam int unsigned BTN_L   = 1;
  localparam int unsigned BTN_R   = 2;
  localparam int unsigned BTN_U   = 3;
  localparam int unsigned BTN_D   = 4;
  localparam int unsigned NUM_BTN = 5;

  // Active-low {dp,g,f,e,d,c,b,a}, dp always off.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/sseg_edit_ctrl_if.sv
// CPU-side load/readback bus of the digit editor.
interface sseg_edit_ctrl_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] value;
  logic        commit;

  modport master (output wr_en, output wr_data, input value, input commit);
  modport slave  (input wr_en, input wr_data, output value, output commit);
endinterface

// File: rtl/sseg_edit_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic             sync1_q, sync2_q, level_q, pulse_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        pulse_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/sseg_edit_ctrl.sv
// Eight-digit hex editor feeding the 7-segment multiplexer; CPU load/readback
// through the bus interface, buttons move the cursor and adjust digits.
module sseg_edit_ctrl
  import sseg_edit_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 2_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_l,
  input  logic                   btn_r,
  input  logic                   btn_u,
  input  logic                   btn_d,
  input  logic                   btn_c,
  sseg_edit_ctrl_if.slave        cpu,
  output logic [7:0]             seg0,
  output logic [7:0]             seg1,
  output logic [7:0]             seg2,
  output logic [7:0]             seg3,
  output logic [7:0]             seg4,
  output logic [7:0]             seg5,
  output logic [7:0]             seg6,
  output logic [7:0]             seg7,
  output logic [2:0]             active_segment,
  output logic                   seg_enable,
  output logic                   editing
);

  logic [NUM_BTN-1:0] btn_raw, pulse;

  assign btn_raw[BTN_C] = btn_c;
  assign btn_raw[BTN_L] = btn_l;
  assign btn_raw[BTN_R] = btn_r;
  assign btn_raw[BTN_U] = btn_u;
  assign btn_raw[BTN_D] = btn_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn_raw[i]),
      .pulse_o (pulse[i])
    );
  end

  state_e      state_q;
  logic [31:0] value_q, shadow_q, timer_q;
  logic [2:0]  cursor_q;
  logic        commit_q, editing_q;
  logic [7:0]  seg_q [8];
  logic [31:0] word;
  logic [3:0]  nib;

  assign word = (state_q == EDIT) ? shadow_q : value_q;
  assign nib  = shadow_q[{cursor_q, 2'b00} +: 4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      value_q   <= '0;
      shadow_q  <= '0;
      timer_q   <= '0;
      cursor_q  <= '0;
      commit_q  <= 1'b0;
      editing_q <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) seg_q[i] <= 8'hC0;
    end else begin
      commit_q <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) seg_q[i] <= hex2seg(word[i*4 +: 4]);
      case (state_q)
        IDLE: begin
          if (cpu.wr_en) begin
            value_q  <= cpu.wr_data;
            shadow_q <= cpu.wr_data;
          end else if (pulse[BTN_C]) begin
            state_q   <= EDIT;
            editing_q <= 1'b1;
            shadow_q  <= value_q;
            cursor_q  <= '0;
            timer_q   <= '0;
          end
        end
        EDIT: begin
          // Any pulse, even one dropped by priority, counts as activity.
          timer_q <= (|pulse) ? '0 : timer_q + 32'd1;
          if (pulse[BTN_C]) begin
            value_q   <= shadow_q;
            commit_q  <= 1'b1;
            state_q   <= IDLE;
            editing_q <= 1'b0;
          end else if (pulse[BTN_L]) begin
            cursor_q <= cursor_q + 3'd1;
          end else if (pulse[BTN_R]) begin
            cursor_q <= cursor_q - 3'd1;
          end else if (pulse[BTN_U]) begin
            shadow_q[{cursor_q, 2'b00} +: 4] <= nib + 4'd1;
          end else if (pulse[BTN_D]) begin
            shadow_q[{cursor_q, 2'b00} +: 4] <= nib - 4'd1;
          end else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= IDLE;
            editing_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          editing_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.value      = value_q;
  assign cpu.commit     = commit_q;
  assign editing        = editing_q;
  assign seg_enable     = editing_q;
  assign active_segment = cursor_q;
  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];
  assign seg6 = seg_q[6];
  assign seg7 = seg_q[7];

endmodule

// File: doc/sseg_edit_ctrl.md
Name: sseg_edit_ctrl

Overview:
- Upstream feeder for the 8-digit 7-segment multiplexer.
- Holds a 32-bit value as 8 hex digits and lets the user edit it digit-by-digit with five board buttons (left/right/up/down/center).
- Drives the multiplexer's eight segment-pattern inputs, blink cursor index and blink enable.
- The CPU can load the value through a one-cycle write strobe and read back the committed value.

Parameters:
- DB_CYCLES, 2_000_000, button stable time in clk cycles before a level is accepted (20 ms at 100 MHz); bench uses 4.
- TIMEOUT_CYCLES, 1_000_000_000, idle cycles in EDIT before the edit is abandoned (10 s); bench uses 1000.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- btn_l, btn_r, btn_u, btn_d, btn_c  in  1 each  raw, asynchronous button levels, active-high.
- wr_en  in  1  CPU load strobe, one cycle.
- wr_data  in  32  CPU load value.
- value  out  32  committed value.
- commit  out  1  one-cycle pulse when an edit is committed.
- editing  out  1  high in EDIT.
- seg0..seg7  out  8 each  active-low patterns {dp,g,f,e,d,c,b,a}; seg0 is the rightmost digit (nibble 3:0).
- active_segment  out  3  cursor digit index.
- seg_enable  out  1  blink enable; equals editing.

Behaviour:
- Reset (async) values:
  - State IDLE; value = 0; shadow = 0; cursor = 0; timer = 0.
  - commit = 0; editing = 0; seg_enable = 0; active_segment = 0.
  - seg0..seg7 = 8'hC0 ("0", dp off).
  - Debouncers are cleared with stable level 0, so no press pulse is produced out of reset.
- Button conditioning, per button:
  - 2-FF synchroniser, then a counter.
  - The accepted level changes only after the synchronised input differs from it for DB_CYCLES consecutive cycles.
  - Press pulse = one cycle on the 0->1 transition of the accepted level. Release produces no pulse.
  - No auto-repeat.
- Simultaneous press pulses in one cycle: only the highest priority acts (c > l > r > u > d); the others are dropped.
- IDLE state:
  - Displayed word = value.
  - wr_en: value <= wr_data, shadow <= wr_data.
  - c pulse: go to EDIT with shadow <= value, cursor <= 0, timer <= 0.
  - If wr_en and a c pulse coincide, wr_en wins and the state stays IDLE.
  - l/r/u/d pulses are ignored.
- EDIT state:
  - Displayed word = shadow; editing = 1.
  - l pulse: cursor <= cursor + 1, mod 8 (7 wraps to 0).
  - r pulse: cursor <= cursor - 1, mod 8 (0 wraps to 7).
  - u pulse: shadow nibble[cursor] <= nibble + 1, mod 16 (F wraps to 0).
  - d pulse: shadow nibble[cursor] <= nibble - 1, mod 16 (0 wraps to F). Other nibbles are unchanged.
  - c pulse: value <= shadow, commit = 1 for the next cycle only, go to IDLE.
  - Timer:
    - Increments every cycle; any accepted pulse clears it.
    - At TIMEOUT_CYCLES - 1 with no pulse: go to IDLE, value unchanged, no commit, shadow discarded.
  - wr_en is ignored in EDIT, and value does not change.
- Outputs:
  - seg0..seg7 are registered hex-to-7-segment decodes of the displayed word, updating 1 cycle after the word changes.
  - dp bit is always 1.
  - active_segment = cursor, registered.
- Latency: debounced press pulse -> state/register update at the next edge -> seg outputs one edge later.
- Reset mid-EDIT: immediate IDLE, value = 0, no commit pulse.

Decomposition:
- Package sseg_edit_pkg holds:
  - state enum {IDLE, EDIT};
  - the 16-entry hex-to-segment constant table (0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E);
  - the button priority index constants.
- One sub-module, btn_debounce (synchroniser + counter + rising-edge pulse, parameter DB_CYCLES), instantiated five times.

Test Plan:
- Load in IDLE: reset, then wr_en with 32'h1234ABCD -> value = 1234ABCD; next cycle seg0 = A1 (d), seg3 = 88 (A), seg7 = F9 (1); seg_enable = 0.
- Edit with wrap: from 1234ABCD, press c, l x3, u x3, c:
  - cursor goes 0->3 and nibble A->B->C->D;
  - commit pulses exactly one cycle; value = 1234DBCD; editing returns to 0.
- Cursor and digit wrap: in EDIT press r once -> active_segment = 7; press d on digit 7 = 0 -> nibble F, value unchanged until commit.
- Debounce: with DB_CYCLES = 4, a btn_u glitch of 3 cycles -> no change; a 20-cycle press with 2-cycle bounces at start -> exactly one increment.
- Timeout: enter EDIT, press u, then idle 1000 cycles -> IDLE; value unchanged; commit never asserted.
- Priority and reset: btn_c and btn_u both rise in the same cycle while in EDIT -> commit only, no increment. Assert reset mid-EDIT -> value = 0, seg0..seg7 = C0, state IDLE.
